ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Driver end of the configuration-chain protocol (ccff_head -> ... -> ccff_tail) used by routing and CB tiles.
//  Accepts configuration words over valid/ready, serialises them MSB-first onto ccff_head, and gates chain shifting via chain_clk_en.
//  Optional verify pass recirculates the chain (tail -> head) for CHAIN_LEN cycles, so contents are preserved.
//  During that pass it compares the ones-count read back on ccff_tail against the ones-count loaded.
// PARAMETERS
//  WORD_W     8    bits per cfg_data word
//  CHAIN_LEN  36   total flops in the downstream chain (e.g. 9 muxes x 4 sram bits)
//  CNT_W      $clog2(CHAIN_LEN+1)  width of bit counters
// PORTS
//  prog_clk      in   1       configuration clock; all state on rising edge
//  prog_reset    in   1       asynchronous, active-high reset
//  start         in   1       begin a load; sampled only in IDLE
//  verify_en     in   1       sampled with start; 1 = run VERIFY after LOAD
//  cfg_data      in   WORD_W  configuration word, bit [WORD_W-1] shifted first
//  cfg_valid     in   1       cfg_data valid
//  cfg_ready     out  1       loader accepts cfg_data this cycle
//  ccff_head     out  1       serial bit into chain head
//  ccff_tail     in   1       serial bit from chain tail
//  chain_clk_en  out  1       1 = chain flops shift on this prog_clk edge
//  busy          out  1       high in LOAD or VERIFY
//  done          out  1       one-cycle pulse on completion
//  verify_err    out  1       sticky mismatch flag, cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters, word shift register, ones counters cleared.
//  FSM: IDLE -start-> LOAD; LOAD -(bits_sent==CHAIN_LEN)-> VERIFY if verify_en latched, else DONE.
//       VERIFY -(bits_read==CHAIN_LEN)-> DONE; DONE -> IDLE (1 cycle, done=1).
//  start while busy or in DONE: ignored. verify_err cleared on the edge that accepts start.
//  LOAD handshake:
//   - cfg_ready=1 when in LOAD, word register empty (bit_idx==0), and bits_sent<CHAIN_LEN.
//   - A word transfers on cfg_valid&cfg_ready.
//  LOAD shifting, word accepted at edge n:
//   - Cycles n+1..n+WORD_W: ccff_head = next bit MSB-first, chain_clk_en=1.
//   - bits_sent increments each such cycle.
//  Back-to-back: cfg_ready asserts in the cycle of the last bit of the current word, so a new word is taken at that edge with no bubble.
//  Starvation: no word held -> chain_clk_en=0, ccff_head=0; chain holds state.
//  Final partial word: when bits_sent reaches CHAIN_LEN mid-word, the remaining bits are discarded, the word register is cleared, and cfg_ready stays 0.
//  load_ones counts 1-bits actually shifted; saturating is unnecessary (CNT_W covers CHAIN_LEN).
//  VERIFY: for exactly CHAIN_LEN cycles, chain_clk_en=1 and ccff_head=ccff_tail (combinational passthrough).
//   - read_ones counts ccff_tail==1 each cycle.
//   - On exit, verify_err set if read_ones!=load_ones.
//  done pulses in DONE for exactly 1 cycle; busy=0 in DONE and IDLE.
//  CHAIN_LEN not a multiple of WORD_W is legal: ceil(CHAIN_LEN/WORD_W) words are consumed.
//  Reset mid-operation: immediate async return to IDLE, chain_clk_en drops at once, and chain contents are undefined (a full reload is required).
//  No output goes X from any legal input sequence; cfg_data is ignored when cfg_valid=0.
// TESTING
//  Bench models the chain as a CHAIN_LEN-bit shift register clocked when chain_clk_en=1.
//  T1 load, no verify:
//   - start,verify_en=0; 5 words 0xA5,0x3C,0xFF,0x00,0x9_ with cfg_valid held.
//   - Chain holds the first 36 bits; done pulses 37 cycles after the first accept (36 shift cycles + 1).
//   - 4 LSBs of word 5 are dropped.
//  T2 starvation:
//   - Drop cfg_valid for 3 cycles between words 2 and 3.
//   - chain_clk_en=0 for those 3 cycles; final chain image is identical to T1.
//  T3 verify pass: T1 with verify_en=1.
//   - 36 extra cycles with head=tail; chain image is unchanged.
//   - verify_err=0; done asserts after VERIFY.
//  T4 verify fault: as T3, but the model forces flop 10 stuck-at-1 while that bit was loaded as 0.
//   - verify_err=1 at done; stays 1 until the next start.
//  T5 reset and ignored start:
//   - prog_reset asserted mid-LOAD at bit 17: all outputs 0 within the same cycle, state IDLE.
//   - Second start pulsed while busy: ignored; bits_sent is not restarted.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Driver end of the configuration chain: serialises cfg words MSB-first onto ccff_head
// and optionally recirculates the chain once to compare ones-counts.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_LOAD   | accepting words and shifting CHAIN_LEN bits into the chain
// ST_VERIFY | CHAIN_LEN cycles of tail->head recirculation, counting ones
// ST_DONE   | one-cycle completion pulse
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 36,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk_i,
    input  logic              prog_reset_i,
    input  logic              start_i,
    input  logic              verify_en_i,
    input  logic [WORD_W-1:0] cfg_data_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    output logic              ccff_head_o,
    input  logic              ccff_tail_i,
    output logic              chain_clk_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              verify_err_o
);

    localparam int IDX_W = $clog2(WORD_W + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(WORD_W);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [1:0]        state_q, state_d;
    logic              verify_q, verify_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  bits_sent_q, bits_sent_d;
    logic [CNT_W-1:0]  bits_read_q, bits_read_d;
    logic [CNT_W-1:0]  load_ones_q, load_ones_d;
    logic [CNT_W-1:0]  read_ones_q, read_ones_d;
    logic              verify_err_q, verify_err_d;

    logic shift_w, last_load_w, verify_w, last_read_w, accept_w;

    assign shift_w     = (state_q == ST_LOAD) && (bit_idx_q != '0);
    assign last_load_w = shift_w && (bits_sent_q == LAST_BIT);
    assign verify_w    = (state_q == ST_VERIFY);
    assign last_read_w = verify_w && (bits_read_q == LAST_BIT);

    // Ready during the last bit of a word gives bubble-free back-to-back transfers.
    assign cfg_ready_o    = (state_q == ST_LOAD) && (bit_idx_q <= IDX_ONE) && !last_load_w;
    assign accept_w       = cfg_valid_i && cfg_ready_o;
    assign chain_clk_en_o = shift_w || verify_w;
    assign ccff_head_o    = shift_w ? word_q[WORD_W-1] : (verify_w ? ccff_tail_i : 1'b0);
    assign busy_o         = (state_q == ST_LOAD) || verify_w;
    assign done_o         = (state_q == ST_DONE);
    assign verify_err_o   = verify_err_q;

    always_comb begin
        state_d      = state_q;
        verify_d     = verify_q;
        word_d       = word_q;
        bit_idx_d    = bit_idx_q;
        bits_sent_d  = bits_sent_q;
        bits_read_d  = bits_read_q;
        load_ones_d  = load_ones_q;
        read_ones_d  = read_ones_q;
        verify_err_d = verify_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_LOAD;
                    verify_d     = verify_en_i;
                    word_d       = '0;
                    bit_idx_d    = '0;
                    bits_sent_d  = '0;
                    bits_read_d  = '0;
                    load_ones_d  = '0;
                    read_ones_d  = '0;
                    verify_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (shift_w) begin
                    word_d      = {word_q[WORD_W-2:0], 1'b0};
                    bit_idx_d   = bit_idx_q - IDX_ONE;
                    bits_sent_d = bits_sent_q + CNT_W'(1);
                    load_ones_d = load_ones_q + CNT_W'(word_q[WORD_W-1]);
                end
                if (accept_w) begin
                    word_d    = cfg_data_i;
                    bit_idx_d = IDX_FULL;
                end
                // Any bits left in a partially shifted final word are dropped here.
                if (last_load_w) begin
                    word_d    = '0;
                    bit_idx_d = '0;
                    state_d   = verify_q ? ST_VERIFY : ST_DONE;
                end
            end
            ST_VERIFY: begin
                bits_read_d = bits_read_q + CNT_W'(1);
                read_ones_d = read_ones_q + CNT_W'(ccff_tail_i);
                if (last_read_w) begin
                    state_d      = ST_DONE;
                    verify_err_d = (read_ones_d != load_ones_q);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk_i or posedge prog_reset_i) begin
        if (prog_reset_i) begin
            state_q      <= ST_IDLE;
            verify_q     <= 1'b0;
            word_q       <= '0;
            bit_idx_q    <= '0;
            bits_sent_q  <= '0;
            bits_read_q  <= '0;
            load_ones_q  <= '0;
            read_ones_q  <= '0;
            verify_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            verify_q     <= verify_d;
            word_q       <= word_d;
            bit_idx_q    <= bit_idx_d;
            bits_sent_q  <= bits_sent_d;
            bits_read_q  <= bits_read_d;
            load_ones_q  <= load_ones_d;
            read_ones_q  <= read_ones_d;
            verify_err_q <= verify_err_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: drives directed cfg words against a
// 36-flop chain model; a negedge monitor checks head bits and completion records.
module tb_ccff_chain_loader;

    localparam logic [35:0] IMAGE = 36'hA53CFF009;

    typedef struct {
        logic [35:0] chain;
        logic        verr;
        int          lat;
        bit          chk_chain;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       verify_en = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready, ccff_head, chain_clk_en, busy, done, verify_err;
    logic       ccff_tail;

    logic [35:0] chain = '0;
    logic        en_s = 1'b0;
    logic        head_s = 1'b0;
    bit          stuck = 1'b0;
    bit          idle_chk = 1'b0;
    int          cyc = 0;
    int          acc_cycle = -1;
    int          bits_pushed = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t sb_q[$];
    logic head_q[$];
    exp_t mon_e;
    logic mon_hb;

    logic [7:0] words [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h96};

    assign ccff_tail = chain[35];

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(36)) dut (
        .prog_clk_i     (clk),
        .prog_reset_i   (rst),
        .start_i        (start),
        .verify_en_i    (verify_en),
        .cfg_data_i     (cfg_data),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .ccff_head_o    (ccff_head),
        .ccff_tail_i    (ccff_tail),
        .chain_clk_en_o (chain_clk_en),
        .busy_o         (busy),
        .done_o         (done),
        .verify_err_o   (verify_err)
    );

    always #5 clk = ~clk;

    // Chain model: flop 0 is the head, flop 35 drives ccff_tail.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en_s)
            chain <= stuck ? ({chain[34:0], head_s} | 36'h400) : {chain[34:0], head_s};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        en_s   = chain_clk_en;
        head_s = ccff_head;
        if (!rst) begin
            if (chain_clk_en && busy && head_q.size() > 0) begin
                mon_hb = head_q.pop_front();
                chk("head_bit", ccff_head, mon_hb);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done_latency", cyc + 1 - acc_cycle, mon_e.lat);
                    chk("verify_err_at_done", verify_err, mon_e.verr);
                    if (mon_e.chk_chain) chk("chain_image", chain, mon_e.chain);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        bit got;
        got = 1'b0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("accept_timeout");
        end else begin
            if (acc_cycle < 0) acc_cycle = cyc + 1;
            if (idle_chk) begin
                chk("stall_clk_en_accept", chain_clk_en, 0);
                idle_chk = 1'b0;
            end
            for (int b = 7; b >= 0; b--) begin
                if (bits_pushed < 36) begin
                    head_q.push_back(w[b]);
                    bits_pushed++;
                end
            end
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic start_load(input logic v, input logic [35:0] ech, input logic everr,
                              input int elat, input bit chkc);
        exp_t e;
        e.chain     = ech;
        e.verr      = everr;
        e.lat       = elat;
        e.chk_chain = chkc;
        sb_q.push_back(e);
        acc_cycle   = -1;
        bits_pushed = 0;
        start       = 1'b1;
        verify_en   = v;
        step();
        start       = 1'b0;
        verify_en   = 1'b0;
    endtask

    // mode 0: back-to-back, 1: 3-cycle starvation after word 2, 2: extra start while busy
    task automatic feed(input int mode);
        for (int i = 0; i < 5; i++) begin
            send_word(words[i]);
            if (i == 1 && mode == 1) begin
                repeat (8) step();
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk("stall_clk_en", chain_clk_en, 0);
                    chk("stall_head", ccff_head, 0);
                    chk("stall_ready", cfg_ready, 1);
                    step();
                end
                idle_chk = 1'b1;
            end
            if (i == 1 && mode == 2) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("done_timeout");
        step();
        chk("head_queue_drained", head_q.size(), 0);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", cfg_ready, 0);
        chk("reset_head", ccff_head, 0);
        chk("reset_clk_en", chain_clk_en, 0);
        chk("reset_verify_err", verify_err, 0);
        rst = 1'b0;
        step();

        // T1: plain load, last word truncated to its top nibble
        start_load(1'b0, IMAGE, 1'b0, 37, 1'b1);
        feed(0);
        wait_done();
        chk("idle_after_done", {busy, done}, 0);

        // T2: starvation between words 2 and 3
        start_load(1'b0, IMAGE, 1'b0, 40, 1'b1);
        feed(1);
        wait_done();

        // T3: load plus verify pass, chain preserved
        start_load(1'b1, IMAGE, 1'b0, 73, 1'b1);
        feed(0);
        wait_done();

        // T4: flop 10 stuck-at-1 makes ones-counts disagree
        stuck = 1'b1;
        start_load(1'b1, IMAGE, 1'b1, 73, 1'b0);
        feed(0);
        wait_done();
        stuck = 1'b0;
        repeat (3) step();
        chk("verify_err_sticky", verify_err, 1);

        // T5a: start while busy is ignored; load completes on schedule
        start_load(1'b0, IMAGE, 1'b0, 37, 1'b1);
        chk("verify_err_cleared_on_start", verify_err, 0);
        feed(2);
        wait_done();

        // T5b: reset while shifting bit 17
        start_load(1'b0, IMAGE, 1'b0, 37, 1'b1);
        send_word(words[0]);
        send_word(words[1]);
        send_word(words[2]);
        chk("busy_before_reset", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_clk_en", chain_clk_en, 0);
        chk("rst_head", ccff_head, 0);
        chk("rst_verify_err", verify_err, 0);
        sb_q.delete();
        head_q.delete();
        step();
        step();
        rst = 1'b0;
        step();

        // Full reload after reset
        start_load(1'b0, IMAGE, 1'b0, 37, 1'b1);
        chk("busy_after_restart", busy, 1);
        feed(0);
        wait_done();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
